mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbiter and sequencer for a single-port unified memory shared by two requesters: the pipeline's instruction-fetch stage (IF) and its data-memory stage (DM). It grants one access at a time and drives the memory port. It returns read data with a one-cycle acknowledge and raises per-requester stall flags, which the pipeline registers use to hold their contents. Data accesses take priority; a starvation counter guarantees fetch progress.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
MEM_LATENCY, 1, cycles from the mem_en_o cycle to valid mem_rdata_i (legal range 1..4)
STARVE_LIMIT, 3, consecutive DM grants with IF pending before IF is forced (legal range 1..7)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
if_req_i  in  1  fetch request, held until if_ack_o
if_addr_i  in  ADDR_WIDTH  fetch byte address
if_rdata_o  out  DATA_WIDTH  fetched instruction, valid when if_ack_o=1
if_ack_o  out  1  one-cycle completion pulse for IF
if_stall_o  out  1  IF must hold its pipeline register
dm_req_i  in  1  data request, held until dm_ack_o
dm_we_i  in  1  1=write, 0=read
dm_addr_i  in  ADDR_WIDTH  data byte address
dm_wdata_i  in  DATA_WIDTH  write data
dm_rdata_o  out  DATA_WIDTH  read data, valid when dm_ack_o=1
dm_ack_o  out  1  one-cycle completion pulse for DM
dm_stall_o  out  1  MEM stage must hold
mem_en_o  out  1  memory access strobe
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_WIDTH  word-aligned memory address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_rdata_i  in  DATA_WIDTH  memory read data

Behaviour:
- Reset: when reset=0 at a rising clk edge:
  - state=IDLE; owner, latency counter and starve counter cleared.
  - Every output register is 0: acks, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o.
  - Reset overrides all requests.
- FSM states: IDLE, ACCESS, WAIT, RESP. Only one access is outstanding at any time.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise select an owner, latch its address, write data and we into registers, and go to ACCESS.
  - Grant rule: if only one requester is active, grant it.
  - If both are active, grant DM unless starve_cnt==STARVE_LIMIT, in which case grant IF.
- ACCESS (1 cycle):
  - mem_en_o=1.
  - mem_we_o=1 only for a DM write.
  - mem_addr_o={latched_addr[ADDR_WIDTH-1:2],2'b00}; mem_wdata_o=latched data.
  - Load the counter with MEM_LATENCY and go to WAIT.
- WAIT:
  - Lasts exactly MEM_LATENCY cycles; mem_en_o=0 and mem_we_o=0.
  - mem_addr_o and mem_wdata_o hold their values.
  - In the final WAIT cycle, mem_rdata_i is registered into the owner's rdata output (writes also capture, and the value is don't-care).
  - Go to RESP.
- RESP (1 cycle): the owner's ack=1 and its rdata output is valid. Always return to IDLE.
- Timing: request first seen in cycle 0 gives mem_en_o in cycle 1 and ack in cycle 2+MEM_LATENCY. Writes take the same latency.
- if_rdata_o and dm_rdata_o hold their last captured value until the next capture for the same requester.
- Starve counter (3 bits):
  - +1 when DM is granted while if_req_i=1, saturating at STARVE_LIMIT.
  - Cleared when IF is granted.
  - Unchanged when DM is granted with if_req_i=0.
- Stall flags: if_stall_o = if_req_i & ~if_ack_o; dm_stall_o = dm_req_i & ~dm_ack_o. These are combinational from registered ack.
- Protocol: a requester drops or changes its request only in the cycle after its ack. The acked requester's request is ignored in that RESP cycle.
- Violation handling: if a requester drops its request mid-access, the access still completes and the ack still pulses.
- Reset mid-operation:
  - The access is abandoned and no ack is generated.
  - A write already strobed in ACCESS is not revoked.

Test Plan:
- Reset, MEM_LATENCY=1: hold reset=0 for 3 cycles with if_req_i=dm_req_i=1 -> all outputs 0 and mem_en_o never 1. Release reset -> first mem_en_o one cycle after the first IDLE cycle.
- Single fetch, MEM_LATENCY=1:
  - Stimulus: if_addr_i=0x00400004; memory returns 0x20080005 in cycle 2.
  - Required: mem_en_o=1 in cycle 1 with mem_addr_o=0x00400004; if_ack_o=1 in cycle 3 with if_rdata_o=0x20080005.
  - Required: if_stall_o=1 in cycles 0-2 and 0 in cycle 3.
- DM write: dm_we_i=1, dm_addr_i=0x10010000, dm_wdata_i=0xDEADBEEF -> cycle 1 shows mem_en_o=mem_we_o=1, mem_addr_o=0x10010000, mem_wdata_o=0xDEADBEEF; dm_ack_o=1 in cycle 3; mem_we_o=0 in every other cycle.
- Contention, STARVE_LIMIT=2: IF holds its request while DM re-requests after each ack -> grant order DM, DM, IF, DM, DM, IF. if_rdata_o returns the value at IF's address at each IF ack.
- Reset mid-WAIT, MEM_LATENCY=3: DM read starts in cycle 0 and reset=0 in cycle 3 -> no dm_ack_o and state is IDLE. A fresh IF read then completes with its ack 5 cycles after its request.
- Alignment: dm_addr_i=0x00400006 read -> mem_addr_o=0x00400004 during ACCESS and WAIT.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch stage (IF) and
// the data-memory stage (DM). One access is in flight at a time. Each access
// runs IDLE -> ACCESS -> WAIT (MEM_LATENCY cycles) -> RESP. Data accesses
// win ties, but a starvation counter forces a fetch grant after STARVE_LIMIT
// consecutive DM grants made while IF was waiting.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-low reset
//   if_req_i/addr_i   fetch request (held until ack) and byte address
//   if_rdata_o/ack_o  fetched word and its one-cycle completion pulse
//   if_stall_o        IF pipeline register must hold
//   dm_req_i/we_i     data request (held until ack), 1 = write
//   dm_addr_i/wdata_i data byte address and write data
//   dm_rdata_o/ack_o  read data and its one-cycle completion pulse
//   dm_stall_o        MEM stage must hold
//   mem_*             memory port: strobe, write enable, word address,
//                     write data, read data (valid MEM_LATENCY cycles after
//                     the strobe)
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_ack_o,
  output logic                  if_stall_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  dm_ack_o,
  output logic                  dm_stall_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] LAT_C    = 3'(MEM_LATENCY);
  localparam logic [2:0] STARVE_C = 3'(STARVE_LIMIT);

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;          // 1 = DM owns the access
  logic [2:0]            lat_cnt_q, lat_cnt_d;
  logic [2:0]            starve_cnt_q, starve_cnt_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  dm_ack_q, dm_ack_d;
  logic                  grant_dm_s;
  logic                  unused_addr_lsb_s;

  // Byte-offset bits never reach the word-addressed memory.
  assign unused_addr_lsb_s = ^{if_addr_i[1:0], dm_addr_i[1:0]};

  // DM wins unless IF is both waiting and has been passed over too often.
  assign grant_dm_s = dm_req_i & ~(if_req_i & (starve_cnt_q == STARVE_C));

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req_i | dm_req_i) begin
          owner_d  = grant_dm_s;
          mem_en_d = 1'b1;
          state_d  = ACCESS;
          if (grant_dm_s) begin
            mem_we_d    = dm_we_i;
            mem_addr_d  = {dm_addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = dm_wdata_i;
            // Only a DM grant that made IF wait counts toward starvation.
            if (if_req_i && (starve_cnt_q < STARVE_C)) begin
              starve_cnt_d = starve_cnt_q + 3'd1;
            end else begin
              starve_cnt_d = starve_cnt_q;
            end
          end else begin
            mem_we_d     = 1'b0;
            mem_addr_d   = {if_addr_i[ADDR_WIDTH-1:2], 2'b00};
            starve_cnt_d = 3'd0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        lat_cnt_d = LAT_C;
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q <= 3'd1) begin
          // Last WAIT cycle: memory data is valid now, so capture and ack.
          if (owner_q) begin
            dm_rdata_d = mem_rdata_i;
            dm_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata_i;
            if_ack_d   = 1'b1;
          end
          lat_cnt_d = 3'd0;
          state_d   = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      RESP: begin
        // The acked requester's held request is ignored here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      lat_cnt_q    <= 3'd0;
      starve_cnt_q <= 3'd0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q  <= {DATA_WIDTH{1'b0}};
      if_rdata_q   <= {DATA_WIDTH{1'b0}};
      dm_rdata_q   <= {DATA_WIDTH{1'b0}};
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;

  // Stall until the ack pulse; combinational from the registered ack.
  assign if_stall_o = if_req_i & ~if_ack_q;
  assign dm_stall_o = dm_req_i & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized
// requesters, checked every cycle against a transaction-level model that
// predicts strobe/ack cycles from the grant cycle with plain arithmetic.
module tb_mem_port_arbiter;
  localparam int LAT   = 3;
  localparam int STV   = 2;
  localparam int BOUND = 60;

  logic        clk;
  logic        reset;
  logic        if_req_i, dm_req_i, dm_we_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ack_o, if_stall_o, dm_ack_o, dm_stall_o, mem_en_o, mem_we_o;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(STV)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_ack_o(if_ack_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o), .dm_stall_o(dm_stall_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errs   = 0;
  int unsigned cyc      = 0;

  // Memory seen by the DUT, memory expected by the model, scheduled read data.
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] sched   [int unsigned];

  // Model state: one transaction record plus the values outputs should hold.
  bit          m_valid = 1'b0;
  bit          t_act   = 1'b0;
  int unsigned t0;
  bit          t_dm, t_we;
  logic [31:0] t_addr, t_rdata;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_dm_rd;
  bit          m_wd_known, m_dm_known;
  int          starve;
  bit          exp_if_ack = 1'b0, exp_dm_ack = 1'b0;

  // Random requester agents.
  bit if_pend = 1'b0, dm_pend = 1'b0, if_ack_seen = 1'b0, dm_ack_seen = 1'b0;
  int if_age = 0, dm_age = 0, if_max_age = 0, dm_max_age = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] env_read(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : mem_init(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    env_mem[a] = d;
    ref_mem[a] = d;
  endtask

  // Model: apply this cycle's inputs (reset, capture, grant decision).
  task automatic model_step();
    bit gdm;
    if (!reset) begin
      m_valid = 1'b1; t_act = 1'b0; starve = 0;
      m_addr = 32'h0; m_wdata = 32'h0; m_wd_known = 1'b1;
      m_if_rd = 32'h0; m_dm_rd = 32'h0; m_dm_known = 1'b1;
    end else if (m_valid) begin
      if (t_act && cyc == t0 + LAT + 1) begin
        if (!t_dm) m_if_rd = t_rdata;
        else if (t_we) m_dm_known = 1'b0;
        else begin m_dm_rd = t_rdata; m_dm_known = 1'b1; end
      end
      if (t_act && cyc >= t0 + LAT + 3) t_act = 1'b0;
      if (!t_act && (if_req_i || dm_req_i)) begin
        gdm    = dm_req_i && !(if_req_i && starve == STV);
        t_act  = 1'b1;
        t0     = cyc;
        t_dm   = gdm;
        t_we   = gdm && dm_we_i;
        t_addr = (gdm ? dm_addr_i : if_addr_i) & 32'hFFFF_FFFC;
        m_addr = t_addr;
        if (gdm) begin
          m_wdata = dm_wdata_i; m_wd_known = 1'b1;
          if (if_req_i) starve = (starve + 1 > STV) ? STV : starve + 1;
        end else begin
          m_wd_known = 1'b0; starve = 0;
        end
        if (t_we) ref_mem[t_addr] = dm_wdata_i;
        else t_rdata = ref_read(t_addr);
      end
    end
  endtask

  // Compare registered outputs for the current cycle with the model.
  task automatic check_outputs();
    bit e_en;
    if (m_valid) begin
      e_en       = t_act && cyc == t0 + 1;
      exp_if_ack = t_act && !t_dm && cyc == t0 + LAT + 2;
      exp_dm_ack = t_act && t_dm && cyc == t0 + LAT + 2;
      check_val("mem_en", mem_en_o, e_en);
      check_val("mem_we", mem_we_o, e_en && t_we);
      check_val("if_ack", if_ack_o, exp_if_ack);
      check_val("dm_ack", dm_ack_o, exp_dm_ack);
      check_val("mem_addr", mem_addr_o, m_addr);
      if (m_wd_known) check_val("mem_wdata", mem_wdata_o, m_wdata);
      check_val("if_rdata", if_rdata_o, m_if_rd);
      if (m_dm_known) check_val("dm_rdata", dm_rdata_o, m_dm_rd);
    end
  endtask

  // Memory behaviour: writes land at the strobe, reads return LAT cycles later.
  task automatic env_mem_step();
    if (mem_en_o === 1'b1) begin
      if (mem_we_o === 1'b1) env_mem[mem_addr_o] = mem_wdata_o;
      else sched[cyc + LAT] = env_read(mem_addr_o);
    end
    if (sched.exists(cyc)) begin
      mem_rdata_i = sched[cyc];
      sched.delete(cyc);
    end else begin
      mem_rdata_i = $urandom();
    end
  endtask

  // Close the current cycle and open the next one.
  task automatic tick();
    model_step();
    #1;
    if (m_valid) begin
      check_val("if_stall", if_stall_o, if_req_i & ~exp_if_ack);
      check_val("dm_stall", dm_stall_o, dm_req_i & ~dm_ack_o_exp());
    end
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    env_mem_step();
  endtask

  function automatic bit dm_ack_o_exp();
    return exp_dm_ack;
  endfunction

  // Let outstanding requests finish, dropping each the cycle after its ack.
  task automatic settle();
    bit if_done, dm_done, ia, da;
    if_done = !if_req_i; dm_done = !dm_req_i; ia = 1'b0; da = 1'b0;
    for (int n = 0; n < 100 && !(if_done && dm_done); n++) begin
      if (ia) begin if_req_i = 1'b0; if_done = 1'b1; end
      if (da) begin dm_req_i = 1'b0; dm_done = 1'b1; end
      ia = if_ack_o; da = dm_ack_o;
      tick();
    end
    check_val("settle_done", {if_done, dm_done}, 2'b11);
    tick();
    tick();
  endtask

  // One isolated access with explicit latency/strobe checks.
  task automatic run_single(input string tag, input bit is_dm, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_addr, input bit chk_rd,
                            input logic [31:0] exp_rd);
    int unsigned c0;
    bit got;
    got = 1'b0;
    if (is_dm) begin
      dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = addr;
    end
    c0 = cyc;
    tick();
    check_val({tag, "_strobe_en"}, mem_en_o, 1'b1);
    check_val({tag, "_strobe_we"}, mem_we_o, we);
    check_val({tag, "_strobe_addr"}, mem_addr_o, exp_addr);
    if (we) check_val({tag, "_strobe_wdata"}, mem_wdata_o, wdata);
    for (int n = 0; n < 30 && !got; n++) begin
      if ((is_dm ? dm_ack_o : if_ack_o) === 1'b1) got = 1'b1;
      else tick();
    end
    check_val({tag, "_latency"}, cyc - c0, LAT + 2);
    if (chk_rd) check_val({tag, "_rdata"}, is_dm ? dm_rdata_o : if_rdata_o, exp_rd);
    check_val({tag, "_stall_at_ack"}, is_dm ? dm_stall_o : if_stall_o, 1'b0);
    tick();
    if (is_dm) dm_req_i = 1'b0; else if_req_i = 1'b0;
    tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b1;
  endtask

  // Randomized requesters obeying the hold-until-ack protocol.
  task automatic drive_random();
    reset = ($urandom_range(0, 299) != 0);
    if (if_ack_seen || !if_pend) begin
      if_pend   = ($urandom_range(0, 3) != 0);
      if_req_i  = if_pend;
      if_addr_i = 32'h1000_0000 + 32'($urandom_range(0, 255));
    end
    if (dm_ack_seen || !dm_pend) begin
      dm_pend    = ($urandom_range(0, 2) != 0);
      dm_req_i   = dm_pend;
      dm_we_i    = $urandom_range(0, 1);
      dm_addr_i  = 32'h1000_0000 + 32'($urandom_range(0, 255));
      dm_wdata_i = $urandom();
    end
    if_ack_seen = if_ack_o;
    dm_ack_seen = dm_ack_o;
    if (if_ack_o || !if_req_i || !reset) if_age = 0; else if_age++;
    if (dm_ack_o || !dm_req_i || !reset) dm_age = 0; else dm_age++;
    if (if_age > if_max_age) if_max_age = if_age;
    if (dm_age > dm_max_age) dm_max_age = dm_age;
  endtask

  // Main sequence.
  initial begin
    logic [5:0] order;
    int         k;
    reset = 1'b0;
    if_req_i = 1'b1; dm_req_i = 1'b1; dm_we_i = 1'b0;
    if_addr_i = 32'h0040_0000; dm_addr_i = 32'h1001_0004; dm_wdata_i = 32'h0;
    mem_rdata_i = 32'h0;
    @(posedge clk);
    #1;
    cyc = 1;
    env_mem_step();
    tick();
    tick();
    check_val("reset_mem_en", mem_en_o, 1'b0);
    check_val("reset_if_rdata", if_rdata_o, 32'h0);
    reset = 1'b1;
    settle();

    preload(32'h0040_0004, 32'h2008_0005);
    run_single("fetch", 1'b0, 1'b0, 32'h0040_0004, 32'h0, 32'h0040_0004, 1'b1, 32'h2008_0005);
    run_single("dm_write", 1'b1, 1'b1, 32'h1001_0000, 32'hDEAD_BEEF, 32'h1001_0000, 1'b0, 32'h0);
    run_single("align", 1'b1, 1'b0, 32'h0040_0006, 32'h0, 32'h0040_0004, 1'b1, 32'h2008_0005);

    // Contention: both hold requests; expect DM, DM, IF, DM, DM, IF.
    do_reset(2);
    preload(32'h0040_0010, 32'h1357_9BDF);
    if_req_i = 1'b1; if_addr_i = 32'h0040_0010;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h1001_0000;
    order = 6'b0; k = 0;
    for (int n = 0; n < 200 && k < 6; n++) begin
      tick();
      if (if_ack_o === 1'b1) begin
        check_val("contend_if_rdata", if_rdata_o, 32'h1357_9BDF);
        order[k] = 1'b0; k++;
      end else if (dm_ack_o === 1'b1) begin
        order[k] = 1'b1; k++;
      end
    end
    check_val("contend_order", order, 6'b011011);
    settle();

    // Reset while DM read sits in WAIT: no ack, then a clean IF read.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h1001_0008;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    dm_req_i = 1'b0;
    for (int n = 0; n < 6; n++) begin
      check_val("rst_no_dm_ack", dm_ack_o, 1'b0);
      tick();
    end
    run_single("post_rst_fetch", 1'b0, 1'b0, 32'h0040_0004, 32'h0, 32'h0040_0004, 1'b1, 32'h2008_0005);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      tick();
    end
    reset = 1'b1;
    settle();
    check_val("if_wait_bounded", if_max_age <= BOUND, 1'b1);
    check_val("dm_wait_bounded", dm_max_age <= BOUND, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
